rect_plotter: RTL
=================

Name: rect_plotter

Overview:
Pixel-stream generator that sits directly downstream of the wall datapath, between it and the VGA adapter.
The wall datapath issues one rectangle request (x, y, width, height, colour) for each erase or draw step.
This block scans the rectangle in raster order and emits one pixel per clock as x_out/y_out/colour_out/plot, suitable for driving the VGA adapter write port.
It clips against the 160x120 screen and signals completion with a one-cycle done pulse.

Parameters:
SCREEN_W, 160, visible width in pixels; x values >= SCREEN_W are clipped
SCREEN_H, 120, visible height in pixels; y values >= SCREEN_H are clipped
X_W, 8, x coordinate and width field bit-width
Y_W, 7, y coordinate and height field bit-width
C_W, 3, colour bit-width

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request strobe; sampled only while busy=0
rect_x  in  X_W  left column of rectangle
rect_y  in  Y_W  top row of rectangle
rect_w  in  X_W  width in pixels (0 = empty)
rect_h  in  Y_W  height in pixels (0 = empty)
rect_colour  in  C_W  fill colour
busy  out  1  high from the edge accepting start until the done cycle ends
done  out  1  one-cycle pulse after the last pixel
x_out  out  X_W  pixel column
y_out  out  Y_W  pixel row
colour_out  out  C_W  pixel colour
plot  out  1  VGA write enable for current pixel

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, busy=0, done=0, plot=0, x_out=0, y_out=0, colour_out=0, counters=0.
- Reset mid-draw aborts immediately (asynchronously). No done pulse is produced. The next start is accepted normally.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On an edge with start=1, latch rect_x/y/w/h/colour and clear cx, cy.
  - Go to SCAN if w!=0 and h!=0; otherwise go to DONE.
  - Inputs are ignored after latching; changes during SCAN have no effect.
- SCAN: one pixel per cycle.
  - Outputs are driven from registered latches and counters only; there is no combinational path from the inputs.
  - x_out = (rect_x+cx) truncated to X_W; y_out = (rect_y+cy) truncated to Y_W; colour_out = latched colour.
  - plot=1 only if the full-width sums satisfy rect_x+cx < SCREEN_W and rect_y+cy < SCREEN_H. Sums are computed in X_W+1 and Y_W+1 bits, so overflow counts as clipped.
  - Clipped pixels still consume their cycle with plot=0, so latency is fixed.
  - Counter advance per edge: cx++. When cx==w-1: cx=0, cy++. When cx==w-1 and cy==h-1: go to DONE.
- DONE: done=1 and plot=0 for exactly one cycle, then IDLE; busy falls at the end of this cycle.
- Timing: with start sampled at edge E0, pixel i appears in the cycle after edge Ei (i=0..N-1, N=w*h). done is high in the cycle after edge EN. An empty rectangle gives done in the cycle after E0.
- start asserted while busy=1 is ignored, not queued. The earliest re-accept is the first edge with busy=0.
- Outside SCAN: plot=0. x_out/y_out/colour_out hold their last values.

Decomposition:
- Shared package game_pkg holds: SCREEN_W, SCREEN_H, X_W, Y_W, C_W, WALL_COLOUR (3'b100), BACKGROUND_COLOUR (3'b111), WALL_WIDTH (10), and the FSM state encoding localparams.
- One natural sub-module, rect_scan_counter: the cx/cy nested counter with load, enable and a last flag. The FSM and clipping logic stay in the top level.

Test Plan:
1. reset; start with x=10, y=20, w=2, h=3, colour=3'b100 -> pixels (10,20),(11,20),(10,21),(11,21),(10,22),(11,22) with plot=1 on 6 consecutive cycles starting the cycle after start; done the 7th cycle; busy low afterwards.
2. Wall draw: x=100, y=0, w=10, h=120, colour=3'b100 -> exactly 1200 plot cycles; last pixel (109,119); one done pulse.
3. Clip: x=155, y=119, w=10, h=2 -> 20 SCAN cycles; plot=1 only for (155..159,119); all y=120 pixels and x>=160 pixels have plot=0.
4. Empty request: w=0, h=5 -> no plot cycles; done the cycle after start; busy for exactly 1 cycle.
5. start re-pulsed and rect_* changed during SCAN of a 4x1 request -> output is the original 4 pixels unchanged, single done pulse.
6. reset asserted during the 3rd pixel of a 4x4 request -> plot/busy/done drop to 0 asynchronously; no done pulse; next request x=0, y=0, w=1, h=1 yields pixel (0,0) then done.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and FSM encoding for the wall game datapath and the rectangle plotter.
package game_pkg;

    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned C_W        = 3;
    localparam int unsigned WALL_WIDTH = 10;

    localparam logic [2:0] WALL_COLOUR       = 3'b100;
    localparam logic [2:0] BACKGROUND_COLOUR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } plot_state_t;

endpackage

// File: rtl/rect_plotter_if.sv
// Request and pixel-stream signals between the wall datapath, the plotter and the VGA adapter.
interface rect_plotter_if #(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7,
    parameter int unsigned C_W = 3
) ();

    logic           start;
    logic [X_W-1:0] rect_x;
    logic [Y_W-1:0] rect_y;
    logic [X_W-1:0] rect_w;
    logic [Y_W-1:0] rect_h;
    logic [C_W-1:0] rect_colour;

    logic           busy;
    logic           done;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] colour_out;
    logic           plot;

    modport master (
        output start, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output busy, done, x_out, y_out, colour_out, plot
    );

endinterface

// File: rtl/rect_plotter_scan_counter.sv
// Nested column/row counter over a latched width x height; last flags the final pixel.
module rect_scan_counter #(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           en,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic [X_W-1:0] w_q;
    logic [Y_W-1:0] h_q;
    logic           row_end;

    assign row_end = (cx == w_q - X_W'(1));
    assign last    = row_end && (cy == h_q - Y_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= '0;
            h_q <= '0;
            cx  <= '0;
            cy  <= '0;
        end else if (load) begin
            w_q <= w;
            h_q <= h;
            cx  <= '0;
            cy  <= '0;
        end else if (en) begin
            if (row_end) begin
                cx <= '0;
                cy <= cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Raster-scans a requested rectangle one pixel per clock, clipping against the screen.
module rect_plotter #(
    parameter int unsigned SCREEN_W = game_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = game_pkg::SCREEN_H,
    parameter int unsigned X_W      = game_pkg::X_W,
    parameter int unsigned Y_W      = game_pkg::Y_W,
    parameter int unsigned C_W      = game_pkg::C_W
) (
    input  logic           clk,
    input  logic           reset,
    rect_plotter_if.slave  bus
);

    import game_pkg::*;

    plot_state_t    state, state_nx;
    logic [X_W-1:0] rx_q;
    logic [Y_W-1:0] ry_q;
    logic [C_W-1:0] col_q;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic           last;
    logic           non_empty;
    logic           load;
    logic           scan_en;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic           in_screen;

    assign non_empty = (bus.rect_w != '0) && (bus.rect_h != '0);
    // Empty requests skip the latch so the pixel outputs keep holding their last values.
    assign load      = (state == IDLE) && bus.start && non_empty;
    assign scan_en   = (state == SCAN) && !last;

    rect_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .en    (scan_en),
        .w     (bus.rect_w),
        .h     (bus.rect_h),
        .cx    (cx),
        .cy    (cy),
        .last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q  <= '0;
            ry_q  <= '0;
            col_q <= '0;
        end else if (load) begin
            rx_q  <= bus.rect_x;
            ry_q  <= bus.rect_y;
            col_q <= bus.rect_colour;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = non_empty ? SCAN : DONE;
            SCAN: if (last)      state_nx = DONE;
            DONE:                state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // Extra carry bit makes coordinate overflow fall outside the screen.
    assign x_sum     = {1'b0, rx_q} + {1'b0, cx};
    assign y_sum     = {1'b0, ry_q} + {1'b0, cy};
    assign in_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.plot       = (state == SCAN) && in_screen;
        bus.x_out      = x_sum[X_W-1:0];
        bus.y_out      = y_sum[Y_W-1:0];
        bus.colour_out = col_q;
    end

endmodule
